// File: rtl/des_key_schedule.sv
// DES key schedule: turns one PC-1-permuted 56-bit key (C0||D0) into the
// sixteen 48-bit round subkeys, streamed over a valid/ready handshake.
// Encrypt order is K1..K16 and decrypt order is K16..K1.
// Optional feature macro: DES_WEAK_KEY_DETECT_EN adds a registered weak_key
// flag that is set when each key half is all zeros or all ones.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        e_i,
    input  logic [55:0] key,
    output logic [47:0] subkey,
    output logic [3:0]  subkey_round,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        busy,
    output logic        done
`ifdef DES_WEAK_KEY_DETECT_EN
    ,
    output logic        weak_key
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    // PC-2 selection: entry j names the 1-based bit of C||D (bit 1 = MSB)
    // that becomes subkey output bit j+1 (output bit 1 = subkey[47]).
    localparam int unsigned PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state_q;
    logic [27:0] c_q, d_q;
    logic [27:0] c_d, d_d;
    logic [3:0]  round_q;
    logic        dir_q;
    logic        valid_q;
    logic        done_q;
    logic [4:0]  encIdx, decIdx;
    logic        encTwo, decTwo;

    // Rounds 1, 2, 9 and 16 rotate by one position, every other round by two.
    function automatic logic isDoubleShift(input logic [4:0] idx);
        return !(idx == 5'd1 || idx == 5'd2 || idx == 5'd9 || idx == 5'd16);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++) begin
            r[47-j] = cd[56-PC2_TABLE[j]];
        end
        return r;
    endfunction

    // Next C/D halves for the round after the one being transferred; encrypt
    // steps forward through the left rotations, decrypt undoes them.
    always_comb begin
        encIdx = {1'b0, round_q} + 5'd2;
        decIdx = 5'd16 - {1'b0, round_q};
        encTwo = isDoubleShift(encIdx);
        decTwo = isDoubleShift(decIdx);
        c_d    = dir_q ? rotl28(c_q, encTwo) : rotr28(c_q, decTwo);
        d_d    = dir_q ? rotl28(d_q, encTwo) : rotr28(d_q, decTwo);
    end

    // Control FSM: accept a start in IDLE, then hand out one subkey per transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        dir_q   <= e_i;
                        round_q <= '0;
                        valid_q <= 1'b1;
                        if (e_i) begin
                            c_q <= rotl28(key[55:28], 1'b0);
                            d_q <= rotl28(key[27:0], 1'b0);
                        end else begin
                            c_q <= key[55:28];
                            d_q <= key[27:0];
                        end
                    end
                end
                RUN: begin
                    if (valid_q && subkey_ready) begin
                        if (round_q == 4'd15) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            round_q <= '0;
                            state_q <= IDLE;
                        end else begin
                            round_q <= round_q + 4'd1;
                            c_q     <= c_d;
                            d_q     <= d_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DES_WEAK_KEY_DETECT_EN
    logic weak_q;

    // Advisory weak-key flag, captured together with the key on start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weak_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            weak_q <= ((key[55:28] == '0) || (key[55:28] == '1)) &&
                      ((key[27:0]  == '0) || (key[27:0]  == '1));
        end
    end

    assign weak_key = weak_q;
`endif

    assign subkey       = pc2({c_q, d_q});
    assign subkey_round = round_q;
    assign subkey_valid = valid_q;
    assign busy         = (state_q == RUN);
    assign done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: FIPS vector in both directions,
// back-pressure, ignored restart, reset abort and random keys, all compared
// against a reference model built from cumulative rotations of C0/D0.
module tb_des_key_schedule;

    logic        clk;
    logic        rst;
    logic        start;
    logic        e_i;
    logic [55:0] key;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        busy;
    logic        done;
`ifdef DES_WEAK_KEY_DETECT_EN
    logic        weak_key;
`endif

    int totalChecks = 0;
    int badChecks   = 0;

    logic [47:0] expKeys [16];
    logic [47:0] cap     [16];
    logic [47:0] encCap  [16];

    localparam logic [55:0] FIPS_KEY = 56'hF0CCAAF556678F;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .e_i          (e_i),
        .key          (key),
        .subkey       (subkey),
        .subkey_round (subkey_round),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .busy         (busy),
        .done         (done)
`ifdef DES_WEAK_KEY_DETECT_EN
        ,
        .weak_key     (weak_key)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        totalChecks++;
        if (got !== want) begin
            badChecks++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: round r uses C0/D0 rotated left by the running total of the
    // shift table, then the PC-2 selection; decrypt is the same list reversed.
    function automatic void buildModel(input logic [55:0] k, input bit enc);
        int sh [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
        int pc2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                         41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
        logic [27:0] c0, d0, c, d;
        logic [55:0] cd;
        logic [47:0] sk;
        int total;
        logic [47:0] fwd [16];
        c0 = k[55:28];
        d0 = k[27:0];
        total = 0;
        for (int r = 0; r < 16; r++) begin
            total += sh[r];
            c = (c0 << (total % 28)) | (c0 >> (28 - (total % 28)));
            d = (d0 << (total % 28)) | (d0 >> (28 - (total % 28)));
            cd = {c, d};
            sk = '0;
            for (int j = 0; j < 48; j++) sk = {sk[46:0], cd[56 - pc2[j]]};
            fwd[r] = sk;
        end
        for (int r = 0; r < 16; r++) expKeys[r] = enc ? fwd[r] : fwd[15 - r];
    endfunction

    // One schedule request. mode 0 = ready high, 1 = random ready.
    // stallRound holds ready low for 5 cycles there; injectRound pulses a
    // conflicting start; resetRound aborts the run with rst.
    task automatic applyStimulus(input logic [55:0] k, input bit enc, input int mode,
                                 input int stallRound, input int injectRound, input int resetRound);
        int idx, cycles, stallCnt;
        bit injected;
        buildModel(k, enc);
        key = k; e_i = enc; start = 1'b1; subkey_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        checkOutput("done_after_start", done, 0);
`ifdef DES_WEAK_KEY_DETECT_EN
        checkOutput("weak_key", weak_key,
                    ((k[55:28] == '0) || (k[55:28] == '1)) && ((k[27:0] == '0) || (k[27:0] == '1)));
`endif
        idx = 0; cycles = 0; stallCnt = 0; injected = 0;
        while (idx < 16 && cycles < 300) begin
            checkOutput("valid", subkey_valid, 1);
            checkOutput("busy", busy, 1);
            checkOutput("round", subkey_round, idx);
            checkOutput("subkey", subkey, expKeys[idx]);
            if (idx == resetRound) begin
                rst = 1'b1;
                @(posedge clk); @(negedge clk);
                checkOutput("abort_valid", subkey_valid, 0);
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_done", done, 0);
                checkOutput("abort_subkey", subkey, 0);
                rst = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); @(negedge clk);
                    checkOutput("abort_no_done", done, 0);
                end
                return;
            end
            if (idx == stallRound && stallCnt < 5) begin
                subkey_ready = 1'b0;
                stallCnt++;
            end else begin
                subkey_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            if (idx == injectRound && !injected) begin
                start = 1'b1; key = ~k; e_i = ~enc; injected = 1;
            end
            if (subkey_ready) cap[idx] = subkey;
            @(posedge clk); @(negedge clk);
            start = 1'b0;
            if (subkey_ready) idx++;
            cycles++;
        end
        subkey_ready = 1'b0;
        checkOutput("xfer_count", idx, 16);
        checkOutput("done_pulse", done, 1);
        checkOutput("valid_end", subkey_valid, 0);
        checkOutput("busy_end", busy, 0);
        if (mode == 0 && stallRound < 0) checkOutput("latency", cycles, 16);
    endtask

    initial begin
        logic [55:0] rk;
        rst = 1'b1; start = 1'b0; e_i = 1'b0; key = '0; subkey_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        checkOutput("reset_valid", subkey_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_round", subkey_round, 0);
        checkOutput("reset_subkey", subkey, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] FIPS encrypt");
        applyStimulus(FIPS_KEY, 1, 0, -1, -1, -1);
        checkOutput("fips_k1", cap[0], 48'h1B02EFFC7072);
        checkOutput("fips_k16", cap[15], 48'hCB3D8B0E17F5);
        for (int i = 0; i < 16; i++) encCap[i] = cap[i];

        $display("[TB] FIPS decrypt (start coincides with done)");
        applyStimulus(FIPS_KEY, 0, 0, -1, -1, -1);
        for (int i = 0; i < 16; i++) checkOutput("dec_reverse", cap[i], encCap[15 - i]);

        $display("[TB] back-pressure");
        applyStimulus(FIPS_KEY, 1, 1, 3, -1, -1);
        for (int i = 0; i < 16; i++) checkOutput("bp_sequence", cap[i], encCap[i]);

        $display("[TB] start during run");
        applyStimulus(FIPS_KEY, 1, 0, -1, 7, -1);
        for (int i = 0; i < 16; i++) checkOutput("inject_sequence", cap[i], encCap[i]);

        $display("[TB] reset abort then rerun");
        applyStimulus(FIPS_KEY, 1, 0, -1, -1, 9);
        applyStimulus(FIPS_KEY, 1, 0, -1, -1, -1);
        for (int i = 0; i < 16; i++) checkOutput("post_reset_sequence", cap[i], encCap[i]);

        $display("[TB] random keys");
        for (int n = 0; n < 8; n++) begin
            rk = {$urandom, $urandom};
            applyStimulus(rk, 1'($urandom_range(0, 1)), $urandom_range(0, 1),
                          (n % 2) ? int'($urandom_range(0, 15)) : -1, -1, -1);
        end

`ifdef DES_WEAK_KEY_DETECT_EN
        $display("[TB] weak keys");
        applyStimulus(56'h0, 1, 0, -1, -1, -1);
        for (int i = 0; i < 16; i++) checkOutput("zero_key_subkey", cap[i], 48'h0);
        applyStimulus(56'hFFFFFFFFFFFFFF, 0, 0, -1, -1, -1);
        applyStimulus(FIPS_KEY, 1, 0, -1, -1, -1);
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
